program_loader: RTL and testbench

Loads a program image from a host halfword stream into `program_memory` through its write port. Reports the instruction count as `pc_max` and gates `run_program` for the instruction-fetch driver. It sits directly upstream of the program driver: it owns memory contents and run permission, and the driver only reads and executes. Errors during a load leave `pc_max` at 0, so nothing executes.

---
 rtl/program_loader.sv | 181 ++++++++++++++++++
 tb/tb_program_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: loads a 32-bit program image from a host halfword stream into
// program memory, reports the loaded instruction count and gates execution.
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to get a running 16-bit
// sum of all accepted halfwords on `checksum`. When it is undefined, `checksum`
// is tied to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   load_start   pulse, starts a new load (ignored while running)
//   s_valid      host halfword valid
//   s_ready      loader accepts a halfword (decoded from state)
//   s_data       halfword, high half of each word first
//   s_last       marks the final halfword of the image
//   run_req      pulse, request execution (honoured only when ready)
//   stop_req     pulse, withdraw execution
//   pm_we        program memory write strobe
//   pm_wr_addr   program memory write address
//   pm_wr_data   program memory write data
//   pc_max       number of instructions loaded (0 on error or mid-load)
//   run_program  execution enable to the fetch driver
//   load_err     sticky load error, cleared by load_start
//   checksum     image checksum, or 0 when the feature is disabled
module program_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data,
  input  logic              s_last,
  input  logic              run_req,
  input  logic              stop_req,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [31:0]       pm_wr_data,
  output logic [31:0]       pc_max,
  output logic              run_program,
  output logic              load_err,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadHi,
    StLoadLo,
    StWrite,
    StReady,
    StRun,
    StErr
  } state_e;

  // word_cnt equals DEPTH exactly when memory is full.
  localparam logic [ADDR_W:0] CntFull = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic [15:0]         hi_q;
  logic                last_q;
  logic                pm_we_q;
  logic [ADDR_W-1:0]   pm_wr_addr_q;
  logic [31:0]         pm_wr_data_q;
  logic [31:0]         pc_max_q;
  logic                run_program_q;
  logic                load_err_q;

  logic                xfer;
  logic                restart;
  logic [ADDR_W:0]     cnt_inc;

  assign s_ready = (state_q == StLoadHi) || (state_q == StLoadLo);
  assign xfer    = s_valid && s_ready;
  // A running program cannot be overwritten underneath the driver.
  assign restart = load_start && (state_q != StRun);
  assign cnt_inc = word_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      word_cnt_q    <= '0;
      hi_q          <= '0;
      last_q        <= 1'b0;
      pm_we_q       <= 1'b0;
      pm_wr_addr_q  <= '0;
      pm_wr_data_q  <= '0;
      pc_max_q      <= '0;
      run_program_q <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      pm_we_q <= 1'b0;
      if (restart) begin
        state_q       <= StLoadHi;
        word_cnt_q    <= '0;
        pc_max_q      <= '0;
        load_err_q    <= 1'b0;
        run_program_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StLoadHi: begin
            if (xfer) begin
              if (word_cnt_q == CntFull || s_last) begin
                // Overflow or odd halfword count: nothing written, nothing runs.
                state_q    <= StErr;
                load_err_q <= 1'b1;
                pc_max_q   <= '0;
              end else begin
                hi_q    <= s_data;
                state_q <= StLoadLo;
              end
            end
          end
          StLoadLo: begin
            if (xfer) begin
              // Strobe is registered here so it is high for the whole WRITE cycle.
              pm_we_q      <= 1'b1;
              pm_wr_addr_q <= word_cnt_q[ADDR_W-1:0];
              pm_wr_data_q <= {hi_q, s_data};
              last_q       <= s_last;
              state_q      <= StWrite;
            end
          end
          StWrite: begin
            word_cnt_q <= cnt_inc;
            if (last_q) begin
              pc_max_q <= 32'(cnt_inc);
              state_q  <= StReady;
            end else begin
              state_q <= StLoadHi;
            end
          end
          StReady: begin
            if (run_req) begin
              run_program_q <= 1'b1;
              state_q       <= StRun;
            end
          end
          StRun: begin
            // stop_req beats a simultaneous run_req.
            if (stop_req) begin
              run_program_q <= 1'b0;
              state_q       <= StReady;
            end
          end
          StErr: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pm_we       = pm_we_q;
  assign pm_wr_addr  = pm_wr_addr_q;
  assign pm_wr_data  = pm_wr_data_q;
  assign pc_max      = pc_max_q;
  assign run_program = run_program_q;
  assign load_err    = load_err_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // A halfword arriving alongside a restart belongs to the abandoned load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (restart) begin
      checksum_q <= '0;
    end else if (xfer) begin
      checksum_q <= checksum_q + s_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic          s_last;
  logic          run_req;
  logic          stop_req;
  logic          pm_we;
  logic [AW-1:0] pm_wr_addr;
  logic [31:0]   pm_wr_data;
  logic [31:0]   pc_max;
  logic          run_program;
  logic          load_err;
  logic [15:0]   checksum;

  int checks = 0;
  int passes = 0;

  // Write log filled by the monitor only.
  int          wr_cnt = 0;
  int          cyc = 0;
  logic [31:0] wr_data_log [64];
  logic [AW-1:0] wr_addr_log [64];
  int          wr_cyc_log [64];

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  program_loader #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .run_req     (run_req),
    .stop_req    (stop_req),
    .pm_we       (pm_we),
    .pm_wr_addr  (pm_wr_addr),
    .pm_wr_data  (pm_wr_data),
    .pc_max      (pc_max),
    .run_program (run_program),
    .load_err    (load_err),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pm_we && wr_cnt < 64) begin
      wr_addr_log[wr_cnt] = pm_wr_addr;
      wr_data_log[wr_cnt] = pm_wr_data;
      wr_cyc_log[wr_cnt]  = cyc;
      wr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  // Presents one halfword and returns just after the edge that accepts it.
  task automatic send_hw(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 20) begin
      step();
      n++;
    end
    if (!s_ready) begin
      checks++;
      $display("FAIL send_hw_timeout: s_ready got 0, required 1 within 20 cycles");
    end else begin
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load_start = 0; s_valid = 0; s_data = 0; s_last = 0;
    run_req = 0; stop_req = 0;
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b required 0", s_ready);
    else passes++;
    checks++; if (pm_we !== 1'b0) $display("FAIL reset_pm_we: got %b required 0", pm_we);
    else passes++;
    checks++; if (pc_max !== 32'd0) $display("FAIL reset_pc_max: got %0d required 0", pc_max);
    else passes++;
    checks++; if (run_program !== 1'b0 || load_err !== 1'b0 || checksum !== 16'h0)
      $display("FAIL reset_flags: got run=%b err=%b cs=%h required 0 0 0000",
               run_program, load_err, checksum);
    else passes++;
  endtask

  task automatic test_basic_load();
    int base;
    base = wr_cnt;
    pulse_load();
    checks++; if (s_ready !== 1'b1) $display("FAIL basic_ready: got %b required 1", s_ready);
    else passes++;
    send_hw(16'h4001, 1'b0);
    send_hw(16'h00AA, 1'b0);
    send_hw(16'h8002, 1'b0);
    send_hw(16'h0081, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (pm_we !== 1'b1 || pm_wr_addr !== 2'd1 || pm_wr_data !== 32'h80020081)
      $display("FAIL basic_write1: got we=%b addr=%0d data=%h required 1 1 80020081",
               pm_we, pm_wr_addr, pm_wr_data);
    else passes++;
    step();
    checks++; if (pc_max !== 32'd2 || pm_we !== 1'b0)
      $display("FAIL basic_pc_max: got pc_max=%0d we=%b required 2 0", pc_max, pm_we);
    else passes++;
    checks++;
    if (wr_cnt - base !== 2 || wr_addr_log[base] !== 2'd0 || wr_data_log[base] !== 32'h400100AA)
      $display("FAIL basic_write0: got n=%0d addr=%0d data=%h required 2 0 400100aa",
               wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
    else passes++;
    checks++; if (wr_cyc_log[base+1] - wr_cyc_log[base] !== 3)
      $display("FAIL basic_throughput: got %0d cycles required 3",
               wr_cyc_log[base+1] - wr_cyc_log[base]);
    else passes++;
    checks++; if (checksum !== (CsumEn ? 16'hC12E : 16'h0000))
      $display("FAIL basic_checksum: got %h required %h", checksum,
               CsumEn ? 16'hC12E : 16'h0000);
    else passes++;
    checks++; if (run_program !== 1'b0)
      $display("FAIL basic_run_before: got %b required 0", run_program);
    else passes++;
    run_req = 1'b1; step(); run_req = 1'b0;
    checks++; if (run_program !== 1'b1) $display("FAIL basic_run: got %b required 1", run_program);
    else passes++;
    // load_start is ignored while running
    pulse_load();
    checks++; if (run_program !== 1'b1 || pc_max !== 32'd2 || s_ready !== 1'b0)
      $display("FAIL run_ignores_load: got run=%b pc_max=%0d rdy=%b required 1 2 0",
               run_program, pc_max, s_ready);
    else passes++;
    stop_req = 1'b1; run_req = 1'b1; step(); stop_req = 1'b0; run_req = 1'b0;
    checks++; if (run_program !== 1'b0)
      $display("FAIL basic_stop_wins: got %b required 0", run_program);
    else passes++;
  endtask

  task automatic test_odd_count();
    int base;
    base = wr_cnt;
    pulse_load();
    send_hw(16'h1234, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (load_err !== 1'b1 || pc_max !== 32'd0 || s_ready !== 1'b0)
      $display("FAIL odd_err: got err=%b pc_max=%0d rdy=%b required 1 0 0",
               load_err, pc_max, s_ready);
    else passes++;
    step(); step();
    checks++; if (wr_cnt - base !== 0) $display("FAIL odd_no_write: got %0d writes required 0",
                                                 wr_cnt - base);
    else passes++;
    checks++; if (checksum !== (CsumEn ? 16'h1234 : 16'h0000))
      $display("FAIL odd_checksum: got %h required %h", checksum,
               CsumEn ? 16'h1234 : 16'h0000);
    else passes++;
    run_req = 1'b1; step(); run_req = 1'b0;
    checks++; if (run_program !== 1'b0 || load_err !== 1'b1)
      $display("FAIL odd_run_ignored: got run=%b err=%b required 0 1", run_program, load_err);
    else passes++;
  endtask

  task automatic test_overflow();
    int base;
    logic [31:0] exp_w;
    base = wr_cnt;
    pulse_load();
    for (int i = 0; i < 4; i++) begin
      send_hw(16'hA000 + 16'(i), 1'b0);
      send_hw(16'h0010 + 16'(i), 1'b0);
    end
    send_hw(16'hBEEF, 1'b0);
    s_valid = 1'b0;
    checks++; if (load_err !== 1'b1 || pc_max !== 32'd0)
      $display("FAIL ovf_err: got err=%b pc_max=%0d required 1 0", load_err, pc_max);
    else passes++;
    step(); step();
    checks++; if (wr_cnt - base !== 4) $display("FAIL ovf_writes: got %0d required 4",
                                                 wr_cnt - base);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      exp_w = {16'hA000 + 16'(i), 16'h0010 + 16'(i)};
      checks++;
      if (wr_addr_log[base+i] !== AW'(i) || wr_data_log[base+i] !== exp_w)
        $display("FAIL ovf_word%0d: got addr=%0d data=%h required %0d %h", i,
                 wr_addr_log[base+i], wr_data_log[base+i], i, exp_w);
      else passes++;
    end
  endtask

  task automatic test_restart();
    int base;
    pulse_load();
    send_hw(16'h1111, 1'b0);
    send_hw(16'h2222, 1'b0);
    send_hw(16'h3333, 1'b0);
    s_valid = 1'b0;
    pulse_load();
    checks++; if (s_ready !== 1'b1 || pc_max !== 32'd0 || load_err !== 1'b0)
      $display("FAIL restart_state: got rdy=%b pc_max=%0d err=%b required 1 0 0",
               s_ready, pc_max, load_err);
    else passes++;
    base = wr_cnt;
    send_hw(16'h5555, 1'b0);
    send_hw(16'h6666, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    step();
    checks++;
    if (pc_max !== 32'd1 || wr_cnt - base !== 1 || wr_addr_log[base] !== 2'd0 ||
        wr_data_log[base] !== 32'h55556666)
      $display("FAIL restart_load: got pc_max=%0d n=%0d addr=%0d data=%h required 1 1 0 55556666",
               pc_max, wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
    else passes++;
    checks++; if (checksum !== (CsumEn ? 16'hBBBB : 16'h0000))
      $display("FAIL restart_checksum: got %h required %h", checksum,
               CsumEn ? 16'hBBBB : 16'h0000);
    else passes++;
    load_start = 1'b1; run_req = 1'b1; step(); load_start = 1'b0; run_req = 1'b0;
    checks++; if (run_program !== 1'b0 || s_ready !== 1'b1 || pc_max !== 32'd0)
      $display("FAIL restart_vs_run: got run=%b rdy=%b pc_max=%0d required 0 1 0",
               run_program, s_ready, pc_max);
    else passes++;
  endtask

  task automatic test_checksum();
    pulse_load();
    send_hw(16'hFFFF, 1'b0);
    send_hw(16'h0002, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    step();
    checks++; if (pc_max !== 32'd1) $display("FAIL csum_pc_max: got %0d required 1", pc_max);
    else passes++;
    checks++; if (checksum !== (CsumEn ? 16'h0001 : 16'h0000))
      $display("FAIL csum_value: got %h required %h", checksum, CsumEn ? 16'h0001 : 16'h0000);
    else passes++;
  endtask

  task automatic test_reset_mid_load();
    int base;
    pulse_load();
    send_hw(16'hABCD, 1'b0);
    base = wr_cnt;
    s_data = 16'h1234; s_last = 1'b1; rst = 1'b0;
    step();
    checks++;
    if (s_ready !== 1'b0 || pm_we !== 1'b0 || pm_wr_addr !== 2'd0 || pm_wr_data !== 32'h0 ||
        pc_max !== 32'd0 || run_program !== 1'b0 || load_err !== 1'b0 || checksum !== 16'h0)
      $display("FAIL midrst_outputs: got rdy=%b we=%b addr=%0d data=%h pc=%0d run=%b err=%b cs=%h required all 0",
               s_ready, pm_we, pm_wr_addr, pm_wr_data, pc_max, run_program, load_err, checksum);
    else passes++;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    step(); step(); step();
    checks++; if (wr_cnt - base !== 0 || s_ready !== 1'b0)
      $display("FAIL midrst_no_write: got n=%0d rdy=%b required 0 0", wr_cnt - base, s_ready);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_odd_count();
    test_overflow();
    test_restart();
    test_checksum();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
